// File: rtl/adc_capture_pkg.sv
// Shared widths and helpers for the ADC sample capture path.
package adc_capture_pkg;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned DIV_W          = 8;
  localparam int unsigned MAX_DECIM_LOG2 = 4;
  localparam int unsigned ACC_W          = DATA_W + MAX_DECIM_LOG2;
  localparam int unsigned DECIM_CFG_W    = 3;
  localparam int unsigned LOG2_W         = $clog2(MAX_DECIM_LOG2 + 1);
  localparam int unsigned WIN_W          = MAX_DECIM_LOG2;
  localparam int unsigned FIFO_DEPTH     = 8;
  localparam int unsigned PTR_W          = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W          = PTR_W + 1;

  // Requested decimation clamped to the largest supported window.
  function automatic logic [LOG2_W-1:0] clamp_decim(input logic [DECIM_CFG_W-1:0] cfg);
    if (cfg > DECIM_CFG_W'(MAX_DECIM_LOG2)) return LOG2_W'(MAX_DECIM_LOG2);
    return LOG2_W'(cfg);
  endfunction

  // Window index of the last sample in a 2^n window.
  function automatic logic [WIN_W-1:0] win_last(input logic [LOG2_W-1:0] n);
    logic [WIN_W:0] span;
    span = (WIN_W + 1)'(1) << n;
    return WIN_W'(span - (WIN_W + 1)'(1));
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous FIFO for decimated samples; drops pushes only when full without a pop.
module adc_sample_fifo
  import adc_capture_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              drop_c
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_pop;
  logic              do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop_c  = push && full && !do_pop;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/adc_sample_capture.sv
// ADC clock divider, mid-period sample capture, boxcar decimation and output FIFO.
module adc_sample_capture
  import adc_capture_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cfg_en,
  input  logic [DIV_W-1:0]       cfg_div,
  input  logic [DECIM_CFG_W-1:0] cfg_decim_log2,
  input  logic                   cfg_clr_overflow,
  output logic                   adc_clock,
  input  logic [DATA_W-1:0]      adc_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_bits,
  output logic [CNT_W-1:0]       fifo_count,
  output logic                   overflow
);

  logic [DIV_W-1:0]  div_cnt;
  logic [DATA_W-1:0] sample_q;
  logic              smp_v;
  logic [ACC_W-1:0]  acc;
  logic [WIN_W-1:0]  win_cnt;
  logic [LOG2_W-1:0] n_q;

  logic              fall_c;
  logic [LOG2_W-1:0] n_eff_c;
  logic              win_done_c;
  logic [ACC_W-1:0]  acc_sum_c;
  logic [DATA_W-1:0] result_c;
  logic              push_c;
  logic              drop_c;
  logic              empty;
  logic              full;

  // Capture on the edge that takes adc_clock low, when ADC data is stable.
  assign fall_c     = cfg_en && (div_cnt == cfg_div) && adc_clock;
  assign n_eff_c    = (win_cnt == '0) ? clamp_decim(cfg_decim_log2) : n_q;
  assign win_done_c = (win_cnt == win_last(n_eff_c));
  assign acc_sum_c  = acc + ACC_W'(sample_q);
  assign result_c   = DATA_W'(acc_sum_c >> n_eff_c);
  assign push_c     = cfg_en && smp_v && win_done_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      adc_clock <= 1'b0;
    end else if (!cfg_en) begin
      div_cnt   <= '0;
      adc_clock <= 1'b0;
    end else if (div_cnt == cfg_div) begin
      div_cnt   <= '0;
      adc_clock <= ~adc_clock;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_q <= '0;
      smp_v    <= 1'b0;
    end else begin
      smp_v <= fall_c;
      if (fall_c) sample_q <= adc_data;
    end
  end

  // Window size is latched on its first sample so a mid-window cfg change is ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      win_cnt <= '0;
      n_q     <= '0;
    end else if (!cfg_en) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (smp_v) begin
      if (win_cnt == '0) n_q <= n_eff_c;
      if (win_done_c) begin
        acc     <= '0;
        win_cnt <= '0;
      end else begin
        acc     <= acc_sum_c;
        win_cnt <= win_cnt + WIN_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 overflow <= 1'b0;
    else if (drop_c)           overflow <= 1'b1;
    else if (cfg_clr_overflow) overflow <= 1'b0;
  end

  adc_sample_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .push_data (result_c),
    .pop       (out_ready),
    .head      (out_bits),
    .empty     (empty),
    .full      (full),
    .count     (fifo_count),
    .drop_c    (drop_c)
  );

  assign out_valid = !empty;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Scoreboard bench for adc_sample_capture: stimulus predicts results, a monitor checks them.
module tb_adc_sample_capture;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_en = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic [2:0] cfg_decim_log2 = 3'd0;
  logic       cfg_clr_overflow = 1'b0;
  logic       adc_clock;
  logic [7:0] adc_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_bits;
  logic [3:0] fifo_count;
  logic       overflow;

  adc_sample_capture dut (
    .clock            (clock),
    .reset            (reset),
    .cfg_en           (cfg_en),
    .cfg_div          (cfg_div),
    .cfg_decim_log2   (cfg_decim_log2),
    .cfg_clr_overflow (cfg_clr_overflow),
    .adc_clock        (adc_clock),
    .adc_data         (adc_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_bits         (out_bits),
    .fifo_count       (fifo_count),
    .overflow         (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   stim_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_ovf = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference FIFO: the scoreboard itself, which holds at most FIFO_DEPTH while nobody pops.
  task automatic model_push(input int v, input int vis_cyc);
    exp_t e;
    if (!out_ready && sb.size() >= 8) begin
      exp_ovf = 1;
    end else begin
      e.data = v;
      e.cyc  = vis_cyc;
      sb.push_back(e);
    end
  endtask

  // Monitor: every accepted head must match the oldest predicted result.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %0d expected none", out_bits);
      end else begin
        e = sb.pop_front();
        chk("out_bits", int'(out_bits), e.data);
        if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  // Runs one enabled burst of nsamp ADC periods; results come from window sums.
  task automatic capture(input int div, input int dcfg, input int nsamp,
                         input bit chk_lat, input bit ready_at_last);
    int p, k, m, sum, cnt, n, v;
    p = 2 * (div + 1);
    sum = 0; cnt = 0; n = 0; k = 0; m = 0;
    cfg_en = 1'b0;
    @(posedge clock); #1;
    cfg_div        = 8'(div);
    cfg_decim_log2 = 3'(dcfg);
    adc_data       = 8'(stim_q[0]);
    cfg_en         = 1'b1;
    while (m < nsamp) begin
      @(posedge clock); #1;
      k++;
      chk("adc_clock", int'(adc_clock), (k / (div + 1)) % 2);
      if (k % p == 0) begin
        v = stim_q[m];
        m++;
        if (cnt == 0) n = (dcfg > 4) ? 4 : dcfg;
        sum += v;
        cnt++;
        if (cnt == (1 << n)) begin
          if (ready_at_last && m == nsamp) out_ready = 1'b1;
          model_push((sum >> n) & 255, chk_lat ? cyc + 1 : -1);
          sum = 0;
          cnt = 0;
        end
        if (m < nsamp) adc_data = 8'(stim_q[m]);
      end
    end
    @(posedge clock); #1;
    if (ready_at_last) begin
      chk("full_pushpop_overflow", int'(overflow), 0);
      chk("full_pushpop_count", int'(fifo_count), 8);
    end
    cfg_en = 1'b0;
  endtask

  task automatic fill_const(input int v, input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(v);
  endtask

  task automatic fill_rand(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(int'($urandom_range(0, 255)));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 300) begin
      @(posedge clock); #1;
      t++;
    end
    chk("drain_done", (sb.size() == 0 && !out_valid) ? 1 : 0, 1);
  endtask

  initial begin
    int n, dcfg, div, t;

    #23 reset = 1'b0;
    @(posedge clock); #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_bits", int'(out_bits), 0);
    chk("reset_fifo_count", int'(fifo_count), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_adc_clock", int'(adc_clock), 0);

    // Divider and single-sample capture at clock/4 and clock/2.
    fill_const(8'h5A, 4);
    capture(1, 0, 4, 1'b1, 1'b0);
    wait_drain();
    fill_rand(4);
    capture(0, 0, 4, 1'b1, 1'b0);
    wait_drain();

    // Boxcar windows of 4 and 16, and an over-range request clamped to 16.
    stim_q.delete();
    stim_q.push_back(10); stim_q.push_back(20); stim_q.push_back(30); stim_q.push_back(41);
    capture(2, 2, 4, 1'b1, 1'b0);
    wait_drain();
    fill_const(255, 16);
    capture(1, 4, 16, 1'b1, 1'b0);
    wait_drain();
    fill_rand(16);
    capture(0, 7, 16, 1'b1, 1'b0);
    wait_drain();

    for (int it = 0; it < 6; it++) begin
      div  = int'($urandom_range(0, 3));
      dcfg = int'($urandom_range(0, 7));
      n    = (dcfg > 4) ? 4 : dcfg;
      fill_rand((1 << n) * int'($urandom_range(1, 2)));
      capture(div, dcfg, stim_q.size(), 1'b1, 1'b0);
      wait_drain();
    end

    // Overflow: nine results into an eight-entry FIFO with no consumer.
    out_ready = 1'b0;
    exp_ovf = 0;
    stim_q.delete();
    for (int i = 1; i <= 9; i++) stim_q.push_back(i);
    capture(1, 0, 9, 1'b0, 1'b0);
    chk("ovf_fifo_count", int'(fifo_count), 8);
    chk("ovf_flag", int'(overflow), exp_ovf);
    chk("ovf_head", int'(out_bits), 1);
    cfg_clr_overflow = 1'b1;
    @(posedge clock); #1;
    cfg_clr_overflow = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);
    fill_const(8'h77, 1);
    capture(1, 0, 1, 1'b0, 1'b1);
    wait_drain();

    // Disable mid-window discards the partial sum.
    out_ready = 1'b1;
    stim_q.delete();
    stim_q.push_back(200); stim_q.push_back(100);
    capture(1, 2, 2, 1'b1, 1'b0);
    @(posedge clock); #1;
    chk("disabled_adc_clock", int'(adc_clock), 0);
    repeat (6) @(posedge clock);
    #1;
    chk("disabled_no_output", int'(out_valid), 0);
    fill_const(8, 4);
    capture(1, 2, 4, 1'b1, 1'b0);
    wait_drain();

    // Asynchronous reset with three entries held and adc_clock high.
    out_ready = 1'b0;
    fill_rand(3);
    capture(0, 0, 3, 1'b0, 1'b0);
    chk("pre_reset_count", int'(fifo_count), 3);
    cfg_div = 8'd1;
    cfg_decim_log2 = 3'd0;
    cfg_en = 1'b1;
    t = 0;
    while (!adc_clock && t < 10) begin
      @(posedge clock); #1;
      t++;
    end
    chk("pre_reset_adc_clock_high", int'(adc_clock), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_fifo_count", int'(fifo_count), 0);
    chk("async_adc_clock", int'(adc_clock), 0);
    chk("async_overflow", int'(overflow), 0);
    sb.delete();
    cfg_en = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("final_scoreboard_empty", sb.size(), 0);
    chk("final_no_output", int'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_sample_capture.md
Name: adc_sample_capture

Overview:
- Digital-side consumer of the ADC interface between the Digital and analog shells.
- Generates adc_clock by dividing the core clock, captures adc_data[7:0] once per adc_clock period, and optionally decimates by boxcar averaging of 2^N samples.
- Buffers results in a small FIFO with a ready/valid output toward the SoC peripheral (MMIO/DMA) side.

Parameters:
- DATA_W, 8, ADC sample width (matches adc_data)
- DIV_W, 8, width of the clock-divider setting
- MAX_DECIM_LOG2, 4, largest supported log2 decimation
- FIFO_DEPTH, 8, output FIFO entries (power of two)

Ports:
- clock, input, 1, core clock
- reset, input, 1, asynchronous active-high reset
- cfg_en, input, 1, capture enable
- cfg_div, input, DIV_W, adc_clock half-period minus one, in core cycles
- cfg_decim_log2, input, 3, log2 of samples averaged per output
- cfg_clr_overflow, input, 1, clears the overflow flag
- adc_clock, output, 1, clock to the ADC
- adc_data, input, DATA_W, ADC conversion result
- out_valid, output, 1, FIFO head valid
- out_ready, input, 1, consumer accepts head
- out_bits, output, DATA_W, FIFO head sample
- fifo_count, output, log2(FIFO_DEPTH)+1, occupancy
- overflow, output, 1, sticky: a result was dropped

Behaviour:
- Clock is clock; reset is asynchronous, active-high.
- Reset values: adc_clock=0, div_cnt=0, acc=0, win_cnt=0, FIFO empty, out_valid=0, out_bits=0, fifo_count=0, overflow=0.
- Divider:
  - While cfg_en=1, div_cnt increments each cycle.
  - When div_cnt==cfg_div: div_cnt returns to 0 and adc_clock toggles.
  - adc_clock period = 2*(cfg_div+1) clock cycles; cfg_div=0 gives clock/2.
  - A cfg_div change takes effect at the next compare. If div_cnt>cfg_div after a change, div_cnt wraps through its maximum value; this is legal and is not checked.
- cfg_en=0:
  - div_cnt and adc_clock are forced to 0 next cycle; acc and win_cnt are cleared.
  - FIFO contents are retained and remain drainable.
  - Re-enabling restarts from div_cnt=0 with adc_clock low.
- Capture:
  - On the edge that drives adc_clock 1->0 (mid-period, ADC data stable), adc_data is registered into sample_q and smp_v is set for one cycle.
- Decimation:
  - N = min(cfg_decim_log2, MAX_DECIM_LOG2), latched when win_cnt==0 at the smp_v cycle.
  - On each smp_v cycle, acc += sample_q and win_cnt increments.
  - When win_cnt reaches 2^N-1, the result (acc+sample_q)>>N is pushed, truncated to DATA_W. acc and win_cnt then return to 0.
  - acc width is DATA_W+MAX_DECIM_LOG2 (12 bits) and cannot overflow.
  - N=0 means every sample is pushed.
- Latency: the falling adc_clock edge is cycle t. The push occurs at edge t+1, and out_valid/out_bits are visible after edge t+1 (registered FIFO state).
- FIFO:
  - out_valid = (count!=0). out_bits = head entry, or 0 when empty.
  - Pop when out_valid&&out_ready. Push when a result is ready.
  - Full with push and no pop: the new result is dropped and overflow is set.
  - Full with simultaneous push and pop: both occur, no overflow, count unchanged.
  - Empty with simultaneous push and pop: the pop is ignored (out_valid=0) and the push proceeds.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Set by a dropped push; cleared by cfg_clr_overflow.
  - Set and clear in the same cycle: set wins.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), and any partial window is discarded.

Decomposition:
- Package adc_capture_pkg holds:
  - DATA_W, MAX_DECIM_LOG2, ACC_W=DATA_W+MAX_DECIM_LOG2
  - FIFO_DEPTH and the pointer/count widths
- Sub-module adc_sample_fifo: synchronous FIFO with push/pop/full/empty/count, same clock and reset.
- Divider, capture and accumulator remain in adc_sample_capture.

Test Plan:
- Divider check: reset, cfg_en=1, cfg_div=1, N=0 -> adc_clock period 4 cycles with 50% duty. cfg_div=0 -> period 2. First rise occurs after cfg_div+1 cycles.
- Single-sample capture: out_ready=1, N=0, adc_data=0x5A held -> out_bits=0x5A with out_valid exactly 1 cycle after each falling adc_clock edge, once per period.
- Decimate by 4: N=2, samples 10, 20, 30, 41 -> a single output of 25 (101>>2) after the fourth capture. Decimate by 16: N=4 with 16×0xFF -> 0xFF. cfg_decim_log2=7 behaves as N=4.
- Overflow: out_ready=0, N=0, samples 1..9 -> fifo_count=8, overflow=1, out_bits=1. Draining yields 1..8 in order. cfg_clr_overflow clears the flag. Full plus simultaneous push/pop -> no overflow.
- Disable mid-window: N=2, two samples captured, then cfg_en=0 -> adc_clock=0 and no output. Re-enable with 4 samples of 8 -> output 8, so the partial window is discarded.
- Async reset with FIFO holding 3 entries and adc_clock high -> immediately out_valid=0, fifo_count=0, adc_clock=0, overflow=0.
